// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock under a
// start/busy/done handshake, results held until the next accepted division.
module seq_restoring_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  rem_work_q, rem_work_d;
  logic [N-1:0]  quo_work_q, quo_work_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    rem_shift;
  logic [N:0]    rem_sub;
  logic          fits;

  // Trial subtraction: the partial remainder always stays below the divisor,
  // so N+1 bits hold the shifted value and the sign of the difference.
  always_comb begin
    rem_shift = {rem_work_q, quo_work_q[N-1]};
    rem_sub   = rem_shift - {1'b0, dsr_q};
    fits      = ~rem_sub[N];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    rem_work_d  = rem_work_q;
    quo_work_d  = quo_work_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dsr_d = divisor;
          if (divisor == '0) begin
            quo_work_d = '1;
            rem_work_d = dividend;
            zero_d     = 1'b1;
            state_d    = ST_FIN;
          end else begin
            quo_work_d = dividend;
            rem_work_d = '0;
            cnt_d      = '0;
            zero_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        rem_work_d = fits ? rem_sub[N-1:0] : rem_shift[N-1:0];
        quo_work_d = {quo_work_q[N-2:0], fits};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        quotient_d  = quo_work_q;
        remainder_d = rem_work_q;
        dbz_d       = zero_q;
        state_d     = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_work_q  <= '0;
      quo_work_q  <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_work_q  <= rem_work_d;
      quo_work_q  <= quo_work_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed vector table, handshake corner
// sequences and random operands against plain-arithmetic expectations.
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start for one edge, then wait for done; optional in-flight checks.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit chk,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic z, output int lat);
    logic [N-1:0] pq;
    logic [N-1:0] pr;
    pq = quotient;
    pr = remainder;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (done) begin
        lat = k;
      end else if (chk) begin
        check("busy_in_flight", int'(busy), int'(b != 0 && k <= N));
        check("quotient_hold", int'(quotient), int'(pq));
        check("remainder_hold", int'(remainder), int'(pr));
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (chk) begin
      check("busy_at_done", int'(busy), 0);
      tick();
      check("done_one_pulse", int'(done), 0);
    end
  endtask

  initial begin
    vec_t         vecs[8];
    logic [N-1:0] q, r;
    logic         z;
    int           lat, ndone, t0, t1;

    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0};
    vecs[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0};
    vecs[5] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, z: 1'b1};
    vecs[6] = '{a: 8'd10,  b: 8'd2,   q: 8'd5,   r: 8'd0,  z: 1'b0};
    vecs[7] = '{a: 8'd180, b: 8'd11,  q: 8'd16,  r: 8'd4,  z: 1'b0};

    // Reset held with start asserted.
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    rst_n = 1'b1;
    start = 1'b0;
    ndone = 0;
    repeat (12) begin
      tick();
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b1, q, r, z, lat);
      check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
      check($sformatf("vec%0d_r", i), int'(r), int'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].b == 0) ? 1 : N + 1);
    end

    // Start while busy is dropped.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    lat   = -1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end
      tick();
      if (k == 3) start = 1'b0;
      if (done) begin
        ndone++;
        lat = k;
        q   = quotient;
        r   = remainder;
      end
    end
    check("busy_rej_ndone", ndone, 1);
    check("busy_rej_latency", lat, N + 1);
    check("busy_rej_q", int'(q), 33);
    check("busy_rej_r", int'(r), 1);

    // Reset mid-operation abandons the division.
    @(negedge clk);
    dividend = 8'd180;
    divisor  = 8'd11;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    ndone = 0;
    repeat (14) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_div(8'd180, 8'd11, 1'b1, q, r, z, lat);
    check("midrst_again_q", int'(q), 16);
    check("midrst_again_r", int'(r), 4);
    check("midrst_again_latency", lat, N + 1);

    // start held high: back-to-back spacing.
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 8'd3;
    start    = 1'b1;
    ndone = 0;
    t0    = 0;
    t1    = 0;
    for (int c = 0; c < 40 && ndone < 2; c++) begin
      tick();
      if (done) begin
        if (ndone == 0) t0 = c;
        else t1 = c;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_ndone", ndone, 2);
    check("b2b_spacing", t1 - t0, N + 2);
    check("b2b_q", int'(quotient), 6);
    check("b2b_r", int'(remainder), 2);
    repeat (12) tick();

    // Random operands against integer division.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] a, b;
      int eq, er, el;
      bit ok;
      a = N'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
      run_div(a, b, 1'b0, q, r, z, lat);
      if (b == 0) begin
        eq = 255;
        er = int'(a);
        el = 1;
      end else begin
        eq = int'(a) / int'(b);
        er = int'(a) % int'(b);
        el = N + 1;
      end
      ok = (int'(q) == eq) && (int'(r) == er) && (z == (b == 0)) && (lat == el);
      if (b != 0) ok = ok && (int'(q) * int'(b) + int'(r) == int'(a)) && (r < b);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL rand %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d lat=%0d",
                    a, b, q, r, z, lat, eq, er, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
